// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory with combinational read.
// Grants one request at a time; partial-byte stores are done as read-modify-write.
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [1:0]                 req_valid_i,
   output logic [1:0]                 req_ready_o,
   input  logic [1:0]                 req_we_i,
   input  logic [1:0][ADDR_W-1:0]     req_addr_i,
   input  logic [1:0][DATA_W-1:0]     req_wdata_i,
   input  logic [1:0][DATA_W/8-1:0]   req_be_i,
   output logic [1:0]                 rsp_valid_o,
   output logic [DATA_W-1:0]          rsp_rdata_o,
   output logic [ADDR_W-1:0]          mem_addr_o,
   output logic [DATA_W-1:0]          mem_wdata_o,
   output logic                       mem_wren_o,
   input  logic [DATA_W-1:0]          mem_rdata_i,
   output logic                       busy_o
);

   localparam int unsigned BE_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;

   state_t            state_q;
   logic              owner_q;
   logic              we_q;
   logic              last_q;
   logic [DATA_W-1:0] wdata_q;
   logic [BE_W-1:0]   be_q;

   logic              win_c;
   logic              grant_c;
   logic [DATA_W-1:0] merged_c;

   // Winner select: round-robin favours the port not granted last on a tie
   always_comb begin
      win_c = 1'b0;
      if (RR_EN) begin
         if (req_valid_i == 2'b11) win_c = ~last_q;
         else                      win_c = req_valid_i[1];
      end else begin
         win_c = ~req_valid_i[0];
      end
   end

   assign grant_c     = (state_q == IDLE) && rst_ni && (|req_valid_i);
   assign req_ready_o = {grant_c & win_c, grant_c & ~win_c};

   // Byte merge of the latched store data over the current memory word
   always_comb begin
      merged_c = mem_rdata_i;
      for (int unsigned i = 0; i < BE_W; i++) begin
         if (be_q[i]) merged_c[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         last_q      <= 1'b1;
         wdata_q     <= '0;
         be_q        <= '0;
         rsp_valid_o <= 2'b00;
         rsp_rdata_o <= '0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_wren_o  <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_c) begin
                  owner_q    <= win_c;
                  last_q     <= win_c;
                  we_q       <= req_we_i[win_c];
                  wdata_q    <= req_wdata_i[win_c];
                  be_q       <= req_be_i[win_c];
                  mem_addr_o <= req_addr_i[win_c];
                  busy_o     <= 1'b1;
                  state_q    <= ACCESS;
                  // Full-word stores are issued straight away in the ACCESS cycle
                  if (req_we_i[win_c] && (&req_be_i[win_c])) begin
                     mem_wren_o  <= 1'b1;
                     mem_wdata_o <= req_wdata_i[win_c];
                  end
               end
            end
            ACCESS: begin
               mem_wren_o  <= 1'b0;
               mem_wdata_o <= '0;
               if (!we_q) begin
                  rsp_rdata_o <= mem_rdata_i;
                  rsp_valid_o <= {owner_q, ~owner_q};
                  state_q     <= RESP;
               end else if ((&be_q) || !(|be_q)) begin
                  rsp_rdata_o <= '0;
                  rsp_valid_o <= {owner_q, ~owner_q};
                  state_q     <= RESP;
               end else begin
                  // mem_wdata_o doubles as the merge holding register
                  mem_wren_o  <= 1'b1;
                  mem_wdata_o <= merged_c;
                  state_q     <= MERGE_WR;
               end
            end
            MERGE_WR: begin
               mem_wren_o  <= 1'b0;
               mem_wdata_o <= '0;
               rsp_rdata_o <= '0;
               rsp_valid_o <= {owner_q, ~owner_q};
               state_q     <= RESP;
            end
            RESP: begin
               rsp_valid_o <= 2'b00;
               busy_o      <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, reset/arbitration sequences and random traffic
// against a word-level memory model.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [1:0]       req_valid, req_ready, req_we, rsp_valid;
   logic [1:0][7:0]  req_addr;
   logic [1:0][31:0] req_wdata;
   logic [1:0][3:0]  req_be;
   logic [31:0]      rsp_rdata, mem_wdata, mem_rdata;
   logic [7:0]       mem_addr;
   logic             mem_wren, busy;

   logic [1:0]       fp_valid, fp_ready, fp_we, fp_rsp_valid;
   logic [1:0][7:0]  fp_addr;
   logic [1:0][31:0] fp_wdata;
   logic [1:0][3:0]  fp_be;
   logic [31:0]      fp_rsp_rdata, fp_mem_wdata, fp_mem_rdata;
   logic [7:0]       fp_mem_addr;
   logic             fp_mem_wren, fp_busy;

   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   assign mem_rdata    = mem[mem_addr];
   assign fp_mem_rdata = 32'h0;
   always @(posedge clk) if (mem_wren) mem[mem_addr] <= mem_wdata;

   dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .RR_EN(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wren_o(mem_wren),
      .mem_rdata_i(mem_rdata), .busy_o(busy)
   );

   dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(fp_valid), .req_ready_o(fp_ready), .req_we_i(fp_we),
      .req_addr_i(fp_addr), .req_wdata_i(fp_wdata), .req_be_i(fp_be),
      .rsp_valid_o(fp_rsp_valid), .rsp_rdata_o(fp_rsp_rdata),
      .mem_addr_o(fp_mem_addr), .mem_wdata_o(fp_mem_wdata), .mem_wren_o(fp_mem_wren),
      .mem_rdata_i(fp_mem_rdata), .busy_o(fp_busy)
   );

   typedef struct {
      int          p;
      logic        we;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [12];
   int          checks = 0;
   int          errors = 0;
   int          model_last = 1;
   int          exp_p;
   logic [1:0]  er, pend_oh;
   logic [7:0]  pend_a;
   logic [31:0] rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   // One transaction on port p; expectations derived from the word-level model
   task automatic xact(input int p, input logic we, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rdo);
      logic [31:0] old, nw, exp_rd;
      logic [1:0]  oh;
      int          wr_off, rsp_off, n;
      oh = (p == 1) ? 2'b10 : 2'b01;
      old = ref_mem[a];
      nw = old;
      exp_rd = 32'h0;
      rdo = 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = d[8*b +: 8];
      if (!we) begin
         exp_rd = old; wr_off = 0; rsp_off = 2;
      end else if (be == 4'hF) begin
         wr_off = 1; rsp_off = 2;
      end else if (be == 4'h0) begin
         wr_off = 0; rsp_off = 2;
      end else begin
         wr_off = 2; rsp_off = 3;
      end
      req_valid[p] = 1'b1; req_we[p] = we; req_addr[p] = a; req_wdata[p] = d; req_be[p] = be;
      #1;
      n = 0;
      while (req_ready !== oh && n < 30) begin
         @(posedge clk); #2; n++;
      end
      chk("grant", 32'(req_ready), 32'(oh));
      if (req_ready !== oh) begin
         req_valid[p] = 1'b0;
         return;
      end
      model_last = p;
      if (we) ref_mem[a] = nw;
      @(posedge clk); #1;
      req_valid[p] = 1'b0;
      #1;
      for (int k = 1; k <= 4; k++) begin
         if (k > 1) begin @(posedge clk); #2; end
         chk("wren", 32'(mem_wren), 32'(k == wr_off));
         chk("wdata", mem_wdata, (k == wr_off) ? nw : 32'h0);
         chk("addr", 32'(mem_addr), 32'(a));
         chk("rsp_valid", 32'(rsp_valid), (k == rsp_off) ? 32'(oh) : 32'h0);
         if (k == rsp_off) begin
            chk("rdata", rsp_rdata, exp_rd);
            rdo = rsp_rdata;
         end
         chk("busy", 32'(busy), 32'(k <= rsp_off));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0};
      tbl[1]  = '{0, 1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF};
      tbl[2]  = '{0, 1'b1, 8'h10, 32'h000000AA, 4'h1, 32'h0};
      tbl[3]  = '{1, 1'b0, 8'h10, 32'h0,        4'h0, 32'hDEADBEAA};
      tbl[4]  = '{1, 1'b1, 8'h20, 32'h12345678, 4'hF, 32'h0};
      tbl[5]  = '{0, 1'b1, 8'h20, 32'hFFFFFFFF, 4'h0, 32'h0};
      tbl[6]  = '{0, 1'b0, 8'h20, 32'h0,        4'h0, 32'h12345678};
      tbl[7]  = '{1, 1'b1, 8'hFF, 32'hCAFEF00D, 4'hF, 32'h0};
      tbl[8]  = '{0, 1'b0, 8'hFF, 32'h0,        4'h0, 32'hCAFEF00D};
      tbl[9]  = '{1, 1'b1, 8'h40, 32'h11223344, 4'hF, 32'h0};
      tbl[10] = '{0, 1'b1, 8'h40, 32'h0000BB00, 4'h2, 32'h0};
      tbl[11] = '{1, 1'b0, 8'h40, 32'h0,        4'h0, 32'h1122BB44};

      rst_n = 1'b0;
      req_valid = 2'b11; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
      fp_valid = 2'b11;  fp_we = '0;  fp_addr = '0;  fp_wdata = '0;  fp_be = '0;
      #12;
      chk("reset_ready", 32'(req_ready), 32'h0);
      chk("reset_fp_ready", 32'(fp_ready), 32'h0);
      chk("reset_addr", 32'(mem_addr), 32'h0);
      chk("reset_wdata", mem_wdata, 32'h0);
      chk("reset_wren", 32'(mem_wren), 32'h0);
      chk("reset_rsp", 32'(rsp_valid), 32'h0);
      chk("reset_rdata", rsp_rdata, 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      req_valid = 2'b00; fp_valid = 2'b00;
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #2;

      // Directed table
      for (int i = 0; i < 12; i++) begin
         xact(tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].be, rd);
         chk("tbl_rsp", rd, tbl[i].exp);
      end

      // Reset during ACCESS of a partial write
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h40;
      req_wdata[0] = 32'hAAAAAAAA; req_be[0] = 4'b0101;
      #1;
      chk("rst_grant", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b0; req_valid = 2'b00;
      #1;
      chk("midrst_addr", 32'(mem_addr), 32'h0);
      chk("midrst_wdata", mem_wdata, 32'h0);
      chk("midrst_wren", 32'(mem_wren), 32'h0);
      chk("midrst_rsp", 32'(rsp_valid), 32'h0);
      chk("midrst_rdata", rsp_rdata, 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_ready", 32'(req_ready), 32'h0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #2;
         chk("inrst_wren", 32'(mem_wren), 32'h0);
         chk("inrst_rsp", 32'(rsp_valid), 32'h0);
      end
      #1; rst_n = 1'b1;
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 8'h40;
      #1;
      chk("post_rst_ready", 32'(req_ready), 32'h2);
      xact(1, 1'b0, 8'h40, 32'h0, 4'h0, rd);
      chk("post_rst_rd", rd, 32'h1122BB44);

      // Round-robin with both ports requesting continuously
      exp_p = 1 - model_last;
      pend_oh = 2'b00; pend_a = 8'h0;
      req_we = 2'b00; req_be = '0; req_addr[0] = 8'h10; req_addr[1] = 8'h20;
      req_valid = 2'b11;
      #1;
      for (int c = 0; c < 12; c++) begin
         er = (c % 3 == 0) ? ((exp_p == 1) ? 2'b10 : 2'b01) : 2'b00;
         chk("arb_ready", 32'(req_ready), 32'(er));
         chk("arb_rsp", 32'(rsp_valid), (c % 3 == 2) ? 32'(pend_oh) : 32'h0);
         if (c % 3 == 2) chk("arb_rdata", rsp_rdata, ref_mem[pend_a]);
         if (c % 3 == 0) begin
            pend_oh = er;
            pend_a = (exp_p == 1) ? 8'h20 : 8'h10;
            model_last = exp_p;
            exp_p = 1 - exp_p;
         end
         if (c == 11) req_valid = 2'b00;
         @(posedge clk); #2;
      end

      // Fixed priority: port 0 keeps winning while it stays valid
      fp_valid = 2'b11;
      #1;
      for (int c = 0; c < 9; c++) begin
         chk("fp_ready", 32'(fp_ready), (c % 3 == 0) ? 32'h1 : 32'h0);
         chk("fp_rsp", 32'(fp_rsp_valid), (c % 3 == 2) ? 32'h1 : 32'h0);
         chk("fp_busy", 32'(fp_busy), (c % 3 == 0) ? 32'h0 : 32'h1);
         chk("fp_wren", 32'(fp_mem_wren), 32'h0);
         chk("fp_wdata", fp_mem_wdata, 32'h0);
         chk("fp_addr", 32'(fp_mem_addr), 32'h0);
         chk("fp_rdata", fp_rsp_rdata, 32'h0);
         if (c == 8) fp_valid = 2'b00;
         @(posedge clk); #2;
      end
      fp_valid = 2'b10;
      #1;
      chk("fp_port1_alone", 32'(fp_ready), 32'h2);
      fp_valid = 2'b00;
      @(posedge clk); #2;

      // Random traffic over a small address window
      for (int i = 0; i < 8; i++)
         xact(int'($urandom_range(0, 1)), 1'b1, 8'h30 + 8'(i), $urandom, 4'hF, rd);
      for (int i = 0; i < 40; i++)
         xact(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'h30 + 8'($urandom_range(0, 7)), $urandom, 4'($urandom), rd);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 256x32 data memory. The memory has a combinational read and a synchronous write-enable.
- Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader.
- The block grants one request at a time and sequences byte-enable stores as read-modify-write.
- It returns one response per accepted request to the owning port.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits wide.
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  2  per-port request valid (bit p = port p)
- req_ready_o  out  2  per-port accept strobe
- req_we_i  in  2  per-port 1 = write, 0 = read
- req_addr_i  in  2xADDR_W  per-port word address
- req_wdata_i  in  2xDATA_W  per-port write data
- req_be_i  in  2x(DATA_W/8)  per-port byte enables, used for writes only
- rsp_valid_o  out  2  per-port one-cycle response strobe
- rsp_rdata_o  out  DATA_W  read data, valid with rsp_valid_o
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_wren_o  out  1  memory write enable
- mem_rdata_i  in  DATA_W  combinational memory read data
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_ni low, asynchronous):
  - FSM goes to IDLE.
  - mem_addr_o, mem_wdata_o, mem_wren_o, rsp_valid_o, rsp_rdata_o, busy_o all 0.
  - Round-robin pointer favours port 0.
  - req_ready_o is 0 while reset is asserted.
- Reset mid-operation: the request is dropped, no mem_wren_o is issued afterwards, and no response is returned.
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE:
  - If any req_valid_i is high, pick a winner and assert req_ready_o[winner] combinationally in that cycle. Only one ready bit is ever high.
  - Latch owner, we, addr, wdata and be; go to ACCESS.
  - Requesters hold the request stable until ready is seen.
- Arbitration:
  - RR_EN=1: on simultaneous requests, grant the port not granted last. The pointer updates only on a grant.
  - RR_EN=0: port 0 always wins.
- ACCESS (mem_addr_o = latched addr):
  - Read: capture mem_rdata_i into rsp_rdata_o; go to RESP.
  - Write with be all-ones: mem_wren_o=1 and mem_wdata_o=wdata for this cycle; go to RESP.
  - Write with be all-zeros: no wren (no-op); go to RESP.
  - Partial write: merge into a holding register (byte i = be[i] ? wdata byte i : mem_rdata_i byte i); go to MERGE_WR.
- MERGE_WR: mem_wren_o=1, mem_wdata_o = merged word, same address; go to RESP.
- RESP:
  - rsp_valid_o[owner]=1 for exactly one cycle.
  - rsp_rdata_o holds read data for reads and 0 for writes.
  - Go to IDLE; no new grant is made in the RESP cycle.
- Latency from the accept cycle N:
  - Read: response at N+2.
  - Full or no-op write: wren at N+1, response at N+2.
  - Partial write: wren at N+2, response at N+3.
- Throughput: at most one request per 3 cycles (4 for partial writes).
- mem_wren_o is high only in ACCESS (full write) or MERGE_WR, and never for more than one cycle per request.
- mem_addr_o holds its last value while idle. mem_wdata_o is 0 whenever mem_wren_o is 0.
- Address wrap-around is not applicable: the full ADDR_W range maps one-to-one to memory words.
- Back-to-back requests from the same port are allowed. A waiting port under RR_EN=1 is granted within one intervening grant.

Test Plan:
- Port 0 write addr 0x10, data 0xDEADBEEF, be 1111, then read 0x10 -> wren pulses once at N+1; read rsp_valid_o[0] at N+2 with rsp_rdata_o=0xDEADBEEF.
- Partial write addr 0x10, data 0x000000AA, be 0001, over 0xDEADBEEF -> wren at N+2 with mem_wdata_o=0xDEADBEAA; a later read returns 0xDEADBEAA.
- Both ports request continuously with RR_EN=1 -> grants alternate 0,1,0,1; each rsp_valid_o goes only to the granted port. With RR_EN=0, only port 0 is granted while its valid stays high.
- Write with be 0000 to addr 0x20 holding 0x12345678 -> no mem_wren_o; rsp_valid_o pulses at N+2; a later read returns 0x12345678.
- Assert rst_ni low during ACCESS of a partial write -> no wren, no response, all outputs 0. After release, an immediate port-1 read is accepted in the first cycle.
- Read addr 0xFF after writing 0xCAFEF00D there -> response 0xCAFEF00D at N+2; busy_o is high for cycles N+1..N+2 only.
